// File: rtl/roulette_spin_generator.sv
// Roulette spin generator: a free-running Galois LFSR sampled at a decelerating
// rate after a key press, with the final sample latched as the 5-bit outcome.
module roulette_spin_generator #(
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int unsigned STEP_BASE = 2,
    parameter int unsigned STEP_INC  = 1,
    parameter int unsigned NUM_STEPS = 8
) (
    input  logic       Clock,
    input  logic       reset_n,
    input  logic       spin_n,
    output logic [4:0] randnum,
    output logic [4:0] spin_value,
    output logic       spinning,
    output logic       result_valid
);

    localparam logic [15:0] POLY      = 16'hB400;
    localparam logic [15:0] BASE_W    = 16'(STEP_BASE);
    localparam logic [15:0] INC_W     = 16'(STEP_INC);
    localparam logic [7:0]  LAST_STEP = 8'(NUM_STEPS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SPIN = 1'b1
    } state_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {1'b0, cur[15:1]} ^ (cur[0] ? POLY : 16'h0000);
    endfunction

    state_t      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic        s1_q, s2_q, s3_q;
    logic [1:0]  fill_q, fill_d;
    logic        armed_q, armed_d;
    logic [15:0] period_q, period_d;
    logic [15:0] period_cnt_q, period_cnt_d;
    logic [7:0]  step_q, step_d;
    logic [4:0]  spin_value_q, spin_value_d;
    logic [4:0]  randnum_q, randnum_d;
    logic        spinning_q, spinning_d;
    logic        result_valid_q, result_valid_d;
    logic        press_s;
    logic        step_evt_s;

    // The chain only holds real button samples two edges after reset; a press is
    // honoured only once the button has been seen released, so a key held through
    // reset release cannot start a spin.
    assign press_s    = armed_q & s3_q & ~s2_q;
    assign step_evt_s = (period_cnt_q == (period_q - 16'd1));

    // Next-state and output computation for the spin FSM
    always_comb begin
        state_d        = state_q;
        lfsr_d         = lfsr_next(lfsr_q);
        fill_d         = (fill_q == 2'd2) ? fill_q : (fill_q + 2'd1);
        armed_d        = armed_q | ((fill_q == 2'd2) & s2_q);
        period_d       = period_q;
        period_cnt_d   = period_cnt_q;
        step_d         = step_q;
        spin_value_d   = spin_value_q;
        randnum_d      = randnum_q;
        spinning_d     = spinning_q;
        result_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (press_s) begin
                    state_d      = SPIN;
                    period_cnt_d = 16'd0;
                    period_d     = BASE_W;
                    step_d       = 8'd0;
                    spinning_d   = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            SPIN: begin
                if (step_evt_s) begin
                    spin_value_d = lfsr_q[4:0];
                    period_cnt_d = 16'd0;
                    period_d     = period_q + INC_W;
                    step_d       = step_q + 8'd1;
                    if (step_q == LAST_STEP) begin
                        randnum_d      = lfsr_q[4:0];
                        result_valid_d = 1'b1;
                        spinning_d     = 1'b0;
                        state_d        = IDLE;
                    end else begin
                        state_d = SPIN;
                    end
                end else begin
                    period_cnt_d = period_cnt_q + 16'd1;
                end
            end
            default: begin
                state_d    = IDLE;
                spinning_d = 1'b0;
            end
        endcase
    end

    // State, LFSR, synchronizer and output registers
    always_ff @(posedge Clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            lfsr_q         <= SEED;
            s1_q           <= 1'b1;
            s2_q           <= 1'b1;
            s3_q           <= 1'b1;
            fill_q         <= 2'd0;
            armed_q        <= 1'b0;
            period_q       <= 16'd0;
            period_cnt_q   <= 16'd0;
            step_q         <= 8'd0;
            spin_value_q   <= 5'd0;
            randnum_q      <= 5'd0;
            spinning_q     <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            lfsr_q         <= lfsr_d;
            s1_q           <= spin_n;
            s2_q           <= s1_q;
            s3_q           <= s2_q;
            fill_q         <= fill_d;
            armed_q        <= armed_d;
            period_q       <= period_d;
            period_cnt_q   <= period_cnt_d;
            step_q         <= step_d;
            spin_value_q   <= spin_value_d;
            randnum_q      <= randnum_d;
            spinning_q     <= spinning_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign randnum      = randnum_q;
    assign spin_value   = spin_value_q;
    assign spinning     = spinning_q;
    assign result_valid = result_valid_q;

endmodule

// File: tb/tb_roulette_spin_generator.sv
// Scoreboard bench for roulette_spin_generator: default instance plus a
// single-step corner instance, checked against an edge-count reference model.
module tb_roulette_spin_generator;

    localparam int B0 = 2, I0 = 1, N0 = 8;
    localparam int L0 = N0 * B0 + I0 * N0 * (N0 - 1) / 2;
    localparam int L1 = 1;

    typedef struct { int rise; int c; int v; } res_t;
    typedef struct { int e; int v; } step_t;

    logic clk = 1'b0;
    logic rst_n, spin_n0, spin_n1;
    logic [4:0] rn0, sv0, rn1, sv1;
    logic sp0, rv0, sp1, rv1;

    res_t  sq0[$];
    res_t  sq1[$];
    step_t stq0[$];
    int ecnt = 0;
    int last_c0 = 0, last_c1 = 0;
    int cur_sv0 = 0, last_rn0 = 0, last_rn1 = 0;
    int rise_obs0 = 0;
    bit prev_sp0 = 1'b0;
    bit mon_en = 1'b0;
    int ntests = 0, nfail = 0;

    always #5 clk = ~clk;

    roulette_spin_generator dut0 (
        .Clock(clk), .reset_n(rst_n), .spin_n(spin_n0),
        .randnum(rn0), .spin_value(sv0), .spinning(sp0), .result_valid(rv0)
    );

    roulette_spin_generator #(.SEED(16'hACE1), .STEP_BASE(1), .STEP_INC(0), .NUM_STEPS(1)) dut1 (
        .Clock(clk), .reset_n(rst_n), .spin_n(spin_n1),
        .randnum(rn1), .spin_value(sv1), .spinning(sp1), .result_valid(rv1)
    );

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ecnt <= 0;
        else        ecnt <= ecnt + 1;
    end

    // LFSR state after n clock edges since reset release
    function automatic int lfsr_low5(int n);
        logic [15:0] l;
        l = 16'hACE1;
        for (int i = 0; i < n; i++) l = {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
        return int'(l[4:0]);
    endfunction

    task automatic check(string name, int act, int exp);
        ntests++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, ecnt);
        end
    endtask

    // Button sampled high at edge k-1 and low at edge k; accepted if idle at edge k+2.
    task automatic model_press0();
        int k, s, per;
        res_t r;
        step_t st;
        k = ecnt + 1;
        if (k + 2 > last_c0) begin
            r.rise = k + 2;
            r.c = r.rise + L0;
            r.v = lfsr_low5(r.c - 1);
            sq0.push_back(r);
            s = r.rise;
            per = B0;
            for (int j = 0; j < N0; j++) begin
                s = s + per;
                st.e = s;
                st.v = lfsr_low5(s - 1);
                stq0.push_back(st);
                per = per + I0;
            end
            last_c0 = r.c;
        end
    endtask

    task automatic model_press1();
        int k;
        res_t r;
        k = ecnt + 1;
        if (k + 2 > last_c1) begin
            r.rise = k + 2;
            r.c = r.rise + L1;
            r.v = lfsr_low5(r.c - 1);
            sq1.push_back(r);
            last_c1 = r.c;
        end
    endtask

    // All drives happen 1 time unit after a rising edge
    task automatic set0(logic v);
        if (spin_n0 === 1'b1 && v == 1'b0) model_press0();
        spin_n0 = v;
    endtask

    task automatic set1(logic v);
        if (spin_n1 === 1'b1 && v == 1'b0) model_press1();
        spin_n1 = v;
    endtask

    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_randnum0", int'(rn0), 0);
        check("rst_spin_value0", int'(sv0), 0);
        check("rst_spinning0", int'(sp0), 0);
        check("rst_result_valid0", int'(rv0), 0);
        check("rst_lfsr0", int'(dut0.lfsr_q), 16'hACE1);
        check("rst_randnum1", int'(rn1), 0);
        check("rst_spinning1", int'(sp1), 0);
        sq0.delete(); sq1.delete(); stq0.delete();
        last_c0 = 0; last_c1 = 0; cur_sv0 = 0; last_rn0 = 0; last_rn1 = 0;
        prev_sp0 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Monitor for the default instance
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            bit exp_spin;
            exp_spin = (sq0.size() > 0) && (ecnt >= sq0[0].rise) && (ecnt < sq0[0].c);
            check("spinning0", int'(sp0), int'(exp_spin));
            if (sp0 && !prev_sp0) rise_obs0 = ecnt;
            prev_sp0 = sp0;
            while (stq0.size() > 0 && stq0[0].e <= ecnt) begin
                cur_sv0 = stq0[0].v;
                void'(stq0.pop_front());
            end
            check("spin_value0", int'(sv0), cur_sv0);
            if (rv0) begin
                if (sq0.size() == 0) begin
                    check("unexpected_result0", 1, 0);
                end else begin
                    check("result_edge0", ecnt, sq0[0].c);
                    check("spin_length0", ecnt - rise_obs0, L0);
                    check("randnum0", int'(rn0), sq0[0].v);
                    last_rn0 = sq0[0].v;
                    void'(sq0.pop_front());
                end
            end else begin
                if (sq0.size() > 0 && ecnt == sq0[0].c) check("result_valid0_missing", 0, 1);
                check("randnum0_stable", int'(rn0), last_rn0);
            end
        end
    end

    // Monitor for the single-step corner instance
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            bit exp_spin;
            exp_spin = (sq1.size() > 0) && (ecnt >= sq1[0].rise) && (ecnt < sq1[0].c);
            check("spinning1", int'(sp1), int'(exp_spin));
            if (rv1) begin
                if (sq1.size() == 0) begin
                    check("unexpected_result1", 1, 0);
                end else begin
                    check("result_edge1", ecnt, sq1[0].c);
                    check("randnum1", int'(rn1), sq1[0].v);
                    last_rn1 = sq1[0].v;
                    void'(sq1.pop_front());
                end
            end else begin
                if (sq1.size() > 0 && ecnt == sq1[0].c) check("result_valid1_missing", 0, 1);
                check("randnum1_stable", int'(rn1), last_rn1);
            end
            check("spin_value1", int'(sv1), last_rn1);
        end
    end

    initial begin
        rst_n = 1'b1;
        spin_n0 = 1'b1;
        spin_n1 = 1'b1;
        @(posedge clk);
        #1;
        do_reset();
        mon_en = 1'b1;
        cyc(100);

        // single spin
        set0(1'b0); cyc(5); set0(1'b1); cyc(60);

        // second press ten cycles into a spin
        set0(1'b0); cyc(2); set0(1'b1); cyc(10);
        set0(1'b0); cyc(2); set0(1'b1); cyc(60);

        // button held for 200 cycles
        set0(1'b0); cyc(200); set0(1'b1); cyc(5);

        // reset twenty cycles into a spin, then a full spin
        set0(1'b0); cyc(2); set0(1'b1); cyc(20);
        do_reset();
        cyc(5);
        set0(1'b0); cyc(2); set0(1'b1); cyc(60);

        // button held low through reset release
        set0(1'b0);
        do_reset();
        cyc(30);
        set0(1'b1); cyc(3);
        set0(1'b0); cyc(3); set0(1'b1); cyc(60);

        // corner instance: presses every 4 cycles
        for (int i = 0; i < 6; i++) begin
            set1(1'b0); cyc(2); set1(1'b1); cyc(2);
        end
        cyc(10);

        // randomized presses, releases and bounces
        for (int i = 0; i < 14; i++) begin
            cyc($urandom_range(12, 1));
            set0(1'b0);
            cyc($urandom_range(60, 1));
            if ($urandom_range(2, 0) == 0) begin
                set0(1'b1); cyc($urandom_range(3, 1));
                set0(1'b0); cyc($urandom_range(4, 1));
            end
            set0(1'b1);
            if ($urandom_range(1, 0) == 1) begin
                set1(1'b0); cyc($urandom_range(3, 1)); set1(1'b1);
            end
        end

        for (int t = 0; t < 200 && (sq0.size() > 0 || sq1.size() > 0); t++) cyc(1);
        cyc(5);
        check("drain0", sq0.size(), 0);
        check("drain1", sq1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
